wb_vram_ctrl: RTL and testbench
===============================

Name: wb_vram_ctrl

Overview:
- Parametrised Wishbone-slave video RAM: CPU read/write on port A, independent VGA read on port B, one clock.
- Next generation of the text-mode VRAM: configurable width/depth, byte selects, registered ack with defined read latency, and a hardware fill engine for fast screen clear.
- Sits between the CPU Wishbone bus and the VGA character generator.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- DEPTH, 1200, number of words (80x30 text screen).
- ADDR_W, 11, word-index width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- dat_i  in  DATA_W  Wishbone write data.
- adr_i  in  32  Wishbone byte address; bits [ADDR_W+1:2] give word index, bit [ADDR_W+2] selects the register window.
- sel_i  in  DATA_W/8  byte enables.
- we_i  in  1  write enable.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle valid.
- dat_o  out  DATA_W  read data, valid while ack_o=1.
- ack_o  out  1  single-cycle acknowledge.
- vga_addr  in  ADDR_W  VGA word index.
- vga_dout  out  DATA_W  VGA read data.
- busy  out  1  fill engine running.

Behaviour:
- Reset is asynchronous and active-low via rst_n; clock is clk. On rst_n=0: dat_o=0, ack_o=0, vga_dout=0, busy=0, FILL_VAL=0, fill counter=0, bus FSM to IDLE. RAM contents are not reset.
- Address map: adr_i[ADDR_W+2]=0 selects RAM word adr_i[ADDR_W+1:2]. adr_i[ADDR_W+2]=1 selects registers by adr_i[2]:
  - 0 = FILL_VAL (RW, honours sel_i).
  - 1 = CTRL. Write with dat_i[0]=1 starts a fill. Read returns {0..., busy} in bit 0.
- Bus FSM states: IDLE, RD_WAIT, ACK.
  - IDLE: a request is stb_i & cyc_i. A RAM request while busy=1 stays in IDLE (no ack) until busy=0. Register requests are always served.
  - Write accepted at edge N: RAM or register updated at edge N, ack_o=1 during cycle N+1 (go to ACK).
  - Read accepted at edge N: synchronous RAM read issued (go to RD_WAIT). dat_o is registered at edge N+1; ack_o=1 during cycle N+2 (ACK). Register reads follow the same 2-cycle path.
  - ACK: lasts exactly one cycle, then returns to IDLE. stb_i is not sampled during ACK, so back-to-back requests cost write 2 cycles and read 3 cycles.
  - dat_o holds its last value outside ACK.
- Byte writes: only lanes with sel_i[k]=1 are written; sel_i=0 writes nothing but is still acked.
- Out of range (word index >= DEPTH): writes are dropped, reads return 0, ack timing is unchanged.
- Fill engine (FILL_IDLE, FILL_RUN):
  - A CTRL start write at edge N enters FILL_RUN; busy=1 from cycle N+1.
  - One word per cycle, index 0..DEPTH-1, is written with FILL_VAL as latched at start. The last write is at edge N+DEPTH; busy=0 from cycle N+DEPTH+1.
  - A start written while busy is ignored but acked. FILL_VAL writes during a fill do not affect the running fill.
  - The fill engine owns port A while busy.
- VGA port: vga_dout = RAM[vga_addr] registered, 1-cycle latency, reading every cycle. Out of range returns 0. Port B is read-only and is never stalled, including during a fill.
- Simultaneous access: CPU write and VGA read of the same word in the same edge returns the old data on vga_dout (read-first).
- Reset mid-fill: busy drops immediately. Memory is left partially filled; words already written keep FILL_VAL.
- Reset mid-transaction: ack_o=0 immediately; the pending transaction is lost and the master must retry.

Test Plan:
- Write 0x12345678 to word 5, sel=4'hF, then read word 5 -> ack_o one cycle after write accept; read ack two cycles after accept with dat_o=0x12345678.
- Byte select: word 5 = 0x12345678, write 0xAABBCCDD with sel=4'b0101 -> read returns 0x12BB56DD.
- Out of range: write word 1200 with 0xFFFFFFFF, read word 1200 -> acked, dat_o=0. Word 1199 is unchanged.
- Fill with DEPTH=16: FILL_VAL=0xDEADBEEF, write CTRL=1 at edge N -> busy high cycles N+1..N+16. vga_dout reads 0xDEADBEEF at all 16 indices after completion. CTRL read returns 1 during the fill and 0 after.
- Stall during fill: RAM read issued at cycle N+2 of the fill -> no ack until busy=0, then ack two cycles later with fill data. A FILL_VAL read during the fill is acked with no stall.
- Reset mid-fill: assert rst_n=0 at fill index 7 -> busy=0, ack_o=0, dat_o=0 asynchronously. Words 0..6 = FILL_VAL, words 8..15 keep their old contents.

Source files
------------

// File: rtl/wb_vram_ctrl_if.sv
// Wishbone slave bus bundle for the video RAM controller.
interface wb_vram_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]   dat_i;
  logic [31:0]         adr_i;
  logic [DATA_W/8-1:0] sel_i;
  logic                we_i;
  logic                stb_i;
  logic                cyc_i;
  logic [DATA_W-1:0]   dat_o;
  logic                ack_o;

  modport master (
    output dat_i, adr_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  dat_i, adr_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_vram_ctrl.sv
// Wishbone video RAM: CPU port A with byte writes and a fill engine,
// free-running VGA read port B, register window for fill control.
module wb_vram_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1200,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_vram_ctrl_if.slave     wb,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_dout,
  output logic              busy
);
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} bus_state_t;
  typedef enum logic       {FILL_IDLE, FILL_RUN} fill_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  bus_state_t        bus_state;
  fill_state_t       fill_state;
  logic [DATA_W-1:0] dat_q;
  logic              ack_q;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] fill_latch;
  logic [IDX_W-1:0]  fill_cnt;

  logic              req_c;
  logic              is_reg_c;
  logic              reg_ctrl_c;
  logic [ADDR_W-1:0] word_idx_c;
  logic              ram_hit_c;
  logic              accept_c;
  logic              ram_we_c;
  logic              start_c;
  logic              vga_hit_c;
  logic [DATA_W-1:0] ram_rd_c;
  logic [DATA_W-1:0] reg_rd_c;
  logic              unused_adr;

  // Request decode; RAM requests are held off while the fill owns port A
  assign busy       = (fill_state == FILL_RUN);
  assign req_c      = wb.stb_i & wb.cyc_i;
  assign is_reg_c   = wb.adr_i[ADDR_W+2];
  assign reg_ctrl_c = wb.adr_i[2];
  assign word_idx_c = wb.adr_i[ADDR_W+1:2];
  assign ram_hit_c  = ({1'b0, word_idx_c} < DEPTH_X);
  assign accept_c   = (bus_state == IDLE) && req_c && (is_reg_c || !busy);
  assign ram_we_c   = accept_c && wb.we_i && !is_reg_c && ram_hit_c;
  assign start_c    = accept_c && wb.we_i && is_reg_c && reg_ctrl_c && wb.dat_i[0] && !busy;
  assign ram_rd_c   = ram_hit_c ? mem[word_idx_c[IDX_W-1:0]] : '0;
  assign reg_rd_c   = reg_ctrl_c ? {{(DATA_W-1){1'b0}}, busy} : fill_val;
  assign vga_hit_c  = ({1'b0, vga_addr} < DEPTH_X);
  assign unused_adr = ^{wb.adr_i[31:ADDR_W+3], wb.adr_i[1:0]};

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_q;

  // Port A write: fill engine while busy, otherwise byte-masked CPU writes
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[fill_cnt] <= fill_latch;
    end else if (ram_we_c) begin
      for (int k = 0; k < LANES; k++) begin
        if (wb.sel_i[k]) mem[word_idx_c[IDX_W-1:0]][8*k +: 8] <= wb.dat_i[8*k +: 8];
      end
    end
  end

  // Port B: registered VGA read every cycle, read-first against port A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vga_dout <= '0;
    else        vga_dout <= vga_hit_c ? mem[vga_addr[IDX_W-1:0]] : '0;
  end

  // Bus FSM, register file and fill sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state  <= IDLE;
      fill_state <= FILL_IDLE;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      rd_buf     <= '0;
      fill_val   <= '0;
      fill_latch <= '0;
      fill_cnt   <= '0;
    end else begin
      case (bus_state)
        IDLE: begin
          if (accept_c) begin
            if (wb.we_i) begin
              if (is_reg_c && !reg_ctrl_c) begin
                for (int k = 0; k < LANES; k++) begin
                  if (wb.sel_i[k]) fill_val[8*k +: 8] <= wb.dat_i[8*k +: 8];
                end
              end
              ack_q     <= 1'b1;
              bus_state <= ACK;
            end else begin
              rd_buf    <= is_reg_c ? reg_rd_c : ram_rd_c;
              bus_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          dat_q     <= rd_buf;
          ack_q     <= 1'b1;
          bus_state <= ACK;
        end
        ACK: begin
          ack_q     <= 1'b0;
          bus_state <= IDLE;
        end
        default: begin
          ack_q     <= 1'b0;
          bus_state <= IDLE;
        end
      endcase

      if (fill_state == FILL_IDLE) begin
        if (start_c) begin
          fill_state <= FILL_RUN;
          fill_cnt   <= '0;
          fill_latch <= fill_val;
        end
      end else if (fill_cnt == LAST_IDX) begin
        fill_state <= FILL_IDLE;
        fill_cnt   <= '0;
      end else begin
        fill_cnt <= fill_cnt + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_vram_ctrl.sv
// Scoreboard bench for wb_vram_ctrl (DEPTH=16, ADDR_W=5).
module tb_wb_vram_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] REG_FILL = 32'h80;
  localparam logic [31:0] REG_CTRL = 32'h84;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_dout;
  logic          busy;

  wb_vram_ctrl_if #(.DATA_W(DW)) wb ();

  wb_vram_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wb),
    .vga_addr (vga_addr),
    .vga_dout (vga_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          is_rd;
    logic [DW-1:0] dat;
    int            cyc;
    string         name;
  } exp_t;

  exp_t bq[$];
  exp_t vq[$];
  exp_t me;
  exp_t mv;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (wb.ack_o === 1'b1) begin
      if (bq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: ack_o=1 with no pending request (cycle %0d)", cyc);
      end else begin
        me = bq.pop_front();
        chk({me.name, "_ackcyc"}, DW'(cyc), DW'(me.cyc));
        if (me.is_rd) chk({me.name, "_dat"}, wb.dat_o, me.dat);
      end
    end
  end

  // VGA monitor: compare vga_dout on the cycle each entry is due
  always @(negedge clk) begin
    if (vq.size() > 0 && vq[0].cyc == cyc) begin
      mv = vq.pop_front();
      chk(mv.name, vga_dout, mv.dat);
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [DW-1:0] dat,
                      input logic [3:0] sel, input logic [DW-1:0] exp_rd, input string name,
                      input int exp_ack, output int ack_cyc);
    exp_t e;
    logic got;
    @(negedge clk);
    e.is_rd = !we;
    e.dat   = exp_rd;
    e.name  = name;
    e.cyc   = (exp_ack >= 0) ? exp_ack : cyc + (we ? 1 : 2);
    bq.push_back(e);
    wb.adr_i = adr;
    wb.dat_i = dat;
    wb.sel_i = sel;
    wb.we_i  = we;
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (wb.ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    wb.stb_i = 1'b0;
    wb.cyc_i = 1'b0;
    wb.we_i  = 1'b0;
    ack_cyc  = cyc;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no ack within 64 cycles", name);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [DW-1:0] dat, input logic [3:0] sel,
                    input string name, output int ack_cyc);
    xfer(1'b1, adr, dat, sel, '0, name, -1, ack_cyc);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [DW-1:0] exp, input string name,
                    input int exp_ack);
    int dummy;
    xfer(1'b0, adr, '0, 4'h0, exp, name, exp_ack, dummy);
  endtask

  task automatic vchk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    vga_addr = a;
    e.is_rd  = 1'b1;
    e.dat    = exp;
    e.cyc    = cyc + 1;
    e.name   = name;
    vq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    exp_t e;
    wb.dat_i = '0;
    wb.adr_i = '0;
    wb.sel_i = '0;
    wb.we_i  = 1'b0;
    wb.stb_i = 1'b0;
    wb.cyc_i = 1'b0;
    vga_addr = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dat_o", wb.dat_o, '0);
    chk("rst_ack_o", DW'(wb.ack_o), '0);
    chk("rst_vga_dout", vga_dout, '0);
    chk("rst_busy", DW'(busy), '0);
    rst_n = 1'b1;

    // Basic write/read latency and byte lanes
    wr(32'h14, 32'h12345678, 4'hF, "w5", n);
    rd(32'h14, 32'h12345678, "r5", -1);
    wr(32'h14, 32'hAABBCCDD, 4'b0101, "w5_bsel", n);
    rd(32'h14, 32'h12BB56DD, "r5_bsel", -1);
    wr(32'h14, 32'hFFFFFFFF, 4'h0, "w5_sel0", n);
    rd(32'h14, 32'h12BB56DD, "r5_sel0", -1);

    // Out of range: index 16 must not alias word 0
    wr(32'h00, 32'h11111111, 4'hF, "w0", n);
    wr(32'h3C, 32'h0F0F0F0F, 4'hF, "w15", n);
    wr(32'h40, 32'hFFFFFFFF, 4'hF, "w16_oor", n);
    rd(32'h40, 32'h0, "r16_oor", -1);
    rd(32'h7C, 32'h0, "r31_oor", -1);
    rd(32'h00, 32'h11111111, "r0_after_oor", -1);
    rd(32'h3C, 32'h0F0F0F0F, "r15_after_oor", -1);
    vchk(5'd5, 32'h12BB56DD, "vga5");
    vchk(5'd15, 32'h0F0F0F0F, "vga15");
    vchk(5'd16, 32'h0, "vga16_oor");

    // FILL_VAL register with byte selects
    wr(REG_FILL, 32'hDEADBEEF, 4'hF, "wfv", n);
    wr(REG_FILL, 32'h11000000, 4'b1000, "wfv_b3", n);
    rd(REG_FILL, 32'h11ADBEEF, "rfv_b3", -1);
    wr(REG_FILL, 32'hDEADBEEF, 4'hF, "wfv2", n);
    rd(REG_CTRL, 32'h0, "ctrl_idle", -1);

    // Fill A: register access during fill, ignored restart, busy window
    wr(REG_CTRL, 32'h1, 4'hF, "startA", n);
    chk("busyA_start", DW'(busy), 32'h1);
    rd(REG_CTRL, 32'h1, "ctrl_busy", -1);
    rd(REG_FILL, 32'hDEADBEEF, "fv_during_fill", -1);
    wr(REG_FILL, 32'h01234567, 4'hF, "wfv_during_fill", c);
    wr(REG_CTRL, 32'h1, 4'hF, "restart_ignored", c);
    while (cyc < n + 15) @(negedge clk);
    chk("busyA_last", DW'(busy), 32'h1);
    @(negedge clk);
    chk("busyA_done", DW'(busy), 32'h0);
    rd(REG_CTRL, 32'h0, "ctrl_after", -1);
    for (int i = 0; i < DEPTH; i++) vchk(AW'(i), 32'hDEADBEEF, $sformatf("vga_fillA_%0d", i));

    // Fill B: RAM read stalls until the fill completes
    wr(REG_CTRL, 32'h1, 4'hF, "startB", n);
    rd(32'h0C, 32'h01234567, "stall_rd", n + 18);
    @(negedge clk);
    chk("dat_hold", wb.dat_o, 32'h01234567);

    // Fill C: reset after index 6 has been written
    wr(REG_FILL, 32'h5A5A5A5A, 4'hF, "wfv_c", c);
    wr(REG_CTRL, 32'h1, 4'hF, "startC", n);
    while (cyc < n + 7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", DW'(busy), 32'h0);
    chk("rstmid_ack", DW'(wb.ack_o), 32'h0);
    chk("rstmid_dat", wb.dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(REG_FILL, 32'h0, "fv_after_rst", -1);
    for (int i = 0; i < 7; i++) vchk(AW'(i), 32'h5A5A5A5A, $sformatf("vga_part_%0d", i));
    for (int i = 8; i < DEPTH; i++) vchk(AW'(i), 32'h01234567, $sformatf("vga_keep_%0d", i));

    // Same-edge CPU write and VGA read: old data first, new data next cycle
    @(negedge clk);
    c = cyc;
    vga_addr = 5'd9;
    e.is_rd = 1'b1;
    e.dat   = 32'h01234567;
    e.cyc   = c + 2;
    e.name  = "rf_old";
    vq.push_back(e);
    e.dat   = 32'hCAFEF00D;
    e.cyc   = c + 3;
    e.name  = "rf_new";
    vq.push_back(e);
    wr(32'h24, 32'hCAFEF00D, 4'hF, "w9", n);

    repeat (4) @(negedge clk);
    total++;
    if (bq.size() + vq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d bus and %0d vga entries never checked", bq.size(), vq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
